// File: rtl/in_service_ctrl_if.sv
// Signal bundle between the PIC front end (INTA sequencer, command decoder)
// and the in-service register controller.
interface in_service_ctrl_if #(
    parameter int NUM_IRQ = 8
) ();
    localparam int PRI_W = $clog2(NUM_IRQ);

    logic               latch_in_service;
    logic [NUM_IRQ-1:0] interrupt;
    logic               auto_eoi_mode;
    logic               special_mask_mode;
    logic [NUM_IRQ-1:0] interrupt_special_mask;
    logic               cmd_valid;
    logic [2:0]         cmd_code;
    logic [PRI_W-1:0]   cmd_level;
    logic [NUM_IRQ-1:0] in_service_register;
    logic [NUM_IRQ-1:0] highest_level_in_service;
    logic [PRI_W-1:0]   priority_rotate;
    logic               in_service_any;

    modport master (
        output latch_in_service, interrupt, auto_eoi_mode, special_mask_mode,
               interrupt_special_mask, cmd_valid, cmd_code, cmd_level,
        input  in_service_register, highest_level_in_service, priority_rotate,
               in_service_any
    );

    modport slave (
        input  latch_in_service, interrupt, auto_eoi_mode, special_mask_mode,
               interrupt_special_mask, cmd_valid, cmd_code, cmd_level,
        output in_service_register, highest_level_in_service, priority_rotate,
               in_service_any
    );
endinterface

// File: rtl/in_service_ctrl.sv
// Registered in-service register with rotating priority pointer and
// OCW2-style EOI / rotate / set-priority command execution.
module in_service_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    in_service_ctrl_if.slave  bus
);
    localparam int PRI_W = $clog2(NUM_IRQ);

    localparam logic [2:0] CMD_AEOI_ROT_CLR = 3'b000;
    localparam logic [2:0] CMD_NS_EOI       = 3'b001;
    localparam logic [2:0] CMD_SP_EOI       = 3'b011;
    localparam logic [2:0] CMD_AEOI_ROT_SET = 3'b100;
    localparam logic [2:0] CMD_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] CMD_SET_PRI      = 3'b110;
    localparam logic [2:0] CMD_ROT_SP_EOI   = 3'b111;

    logic [NUM_IRQ-1:0] isr_reg, isr_next;
    logic [PRI_W-1:0]   rot_reg, rot_next;
    logic               raeoi_reg, raeoi_next;

    logic [NUM_IRQ-1:0] isr_masked;
    logic [NUM_IRQ-1:0] above_rot;
    logic [NUM_IRQ-1:0] req_upper;
    logic [NUM_IRQ-1:0] highest;
    logic [NUM_IRQ-1:0] irq_lowest;
    logic [NUM_IRQ-1:0] level_onehot;
    logic [NUM_IRQ-1:0] clear_vec;
    logic [NUM_IRQ-1:0] set_vec;
    logic [31:0]        level_ext;
    logic               level_ok;
    logic               cmd_rotate;
    logic [PRI_W-1:0]   highest_idx;
    logic [PRI_W-1:0]   irq_idx;
    logic [PRI_W-1:0]   h_acc [NUM_IRQ+1];
    logic [PRI_W-1:0]   i_acc [NUM_IRQ+1];

    assign isr_masked = isr_reg & ~(bus.special_mask_mode ? bus.interrupt_special_mask
                                                          : {NUM_IRQ{1'b0}});
    assign level_ext  = 32'(bus.cmd_level);
    assign level_ok   = (level_ext < 32'(NUM_IRQ));

    // Levels above the pointer outrank the wrapped-around ones below it.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_level
            assign above_rot[gi]    = (32'(gi) > 32'(rot_reg));
            assign level_onehot[gi] = (level_ext == 32'(gi));
        end
    endgenerate

    assign req_upper  = isr_masked & above_rot;
    assign highest    = (req_upper != '0) ? (req_upper & (~req_upper + NUM_IRQ'(1)))
                                          : (isr_masked & (~isr_masked + NUM_IRQ'(1)));
    // A multi-hot acknowledge rotates to its lowest set level.
    assign irq_lowest = bus.interrupt & (~bus.interrupt + NUM_IRQ'(1));

    assign h_acc[0] = '0;
    assign i_acc[0] = '0;
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_encode
            assign h_acc[gi+1] = h_acc[gi] | (highest[gi]    ? PRI_W'(gi) : '0);
            assign i_acc[gi+1] = i_acc[gi] | (irq_lowest[gi] ? PRI_W'(gi) : '0);
        end
    endgenerate
    assign highest_idx = h_acc[NUM_IRQ];
    assign irq_idx     = i_acc[NUM_IRQ];

    always_comb begin
        clear_vec  = '0;
        rot_next   = rot_reg;
        raeoi_next = raeoi_reg;
        cmd_rotate = 1'b0;
        if (bus.cmd_valid) begin
            case (bus.cmd_code)
                CMD_NS_EOI: clear_vec = highest;
                CMD_SP_EOI: if (level_ok) clear_vec = level_onehot;
                CMD_ROT_NS_EOI: begin
                    if (highest != '0) begin
                        clear_vec  = highest;
                        rot_next   = highest_idx;
                        cmd_rotate = 1'b1;
                    end
                end
                CMD_ROT_SP_EOI: begin
                    if (level_ok) begin
                        clear_vec  = level_onehot;
                        rot_next   = bus.cmd_level;
                        cmd_rotate = 1'b1;
                    end
                end
                CMD_SET_PRI: begin
                    if (level_ok) begin
                        rot_next   = bus.cmd_level;
                        cmd_rotate = 1'b1;
                    end
                end
                CMD_AEOI_ROT_SET: raeoi_next = 1'b1;
                CMD_AEOI_ROT_CLR: raeoi_next = 1'b0;
                default: ;
            endcase
        end
        // The clear uses the pre-edge ISR, so a same-edge set of that bit wins.
        set_vec  = (bus.latch_in_service && !bus.auto_eoi_mode) ? bus.interrupt : '0;
        isr_next = (isr_reg & ~clear_vec) | set_vec;
        if (bus.latch_in_service && bus.auto_eoi_mode && raeoi_reg &&
            (bus.interrupt != '0) && !cmd_rotate) begin
            rot_next = irq_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_reg   <= '0;
            rot_reg   <= PRI_W'(NUM_IRQ - 1);
            raeoi_reg <= 1'b0;
        end else begin
            isr_reg   <= isr_next;
            rot_reg   <= rot_next;
            raeoi_reg <= raeoi_next;
        end
    end

    assign bus.in_service_register      = isr_reg;
    assign bus.highest_level_in_service = highest;
    assign bus.priority_rotate          = rot_reg;
    assign bus.in_service_any           = |isr_masked;
endmodule

// File: tb/tb_in_service_ctrl.sv
// Scoreboard bench: two controllers (8 and 12 levels) driven in lockstep and
// compared against a modulo-walk priority model.
module tb_in_service_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    in_service_ctrl_if #(.NUM_IRQ(8))  bus8  ();
    in_service_ctrl_if #(.NUM_IRQ(12)) bus12 ();

    in_service_ctrl #(.NUM_IRQ(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    in_service_ctrl #(.NUM_IRQ(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

    typedef struct {
        logic        latch;
        logic [31:0] intr;
        logic        aeoi;
        logic        smm;
        logic [31:0] mask;
        logic        cv;
        logic [2:0]  code;
        int          level;
    } stim_t;

    typedef struct {
        logic [31:0] isr;
        int          rot;
        logic        raeoi;
    } mstate_t;

    typedef struct {
        logic [31:0] isr;
        logic [31:0] hi;
        int          rot;
        logic        any;
    } exp_t;

    exp_t    q8[$];
    exp_t    q12[$];
    mstate_t m8;
    mstate_t m12;
    int      checks = 0;
    int      errors = 0;
    logic        allow_illegal = 1'b0;
    logic        cur_aeoi = 1'b0;
    logic        cur_smm  = 1'b0;
    logic [31:0] cur_mask = 32'd0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] vmask(int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic int lowest_idx(logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Walk the levels from one past the lowest-priority level, wrapping mod n.
    function automatic logic [31:0] m_highest(mstate_t s, int n, logic smm, logic [31:0] mask);
        logic [31:0] m;
        m = s.isr & ~(smm ? mask : 32'd0);
        for (int k = 1; k <= n; k++) begin
            int p;
            p = (s.rot + k) % n;
            if (m[p]) return 32'd1 << p;
        end
        return 32'd0;
    endfunction

    function automatic mstate_t m_step(mstate_t s, int n, stim_t st);
        mstate_t     r;
        logic [31:0] h, clr, intr;
        int          lvl;
        bit          cmd_rot;
        r       = s;
        intr    = st.intr & vmask(n);
        lvl     = st.level & ((1 << $clog2(n)) - 1);
        h       = m_highest(s, n, st.smm, st.mask);
        clr     = 32'd0;
        cmd_rot = 1'b0;
        if (st.cv) begin
            case (st.code)
                3'b001: clr = h;
                3'b011: if (lvl < n) clr = 32'd1 << lvl;
                3'b101: if (h != 0) begin clr = h; r.rot = lowest_idx(h); cmd_rot = 1'b1; end
                3'b111: if (lvl < n) begin clr = 32'd1 << lvl; r.rot = lvl; cmd_rot = 1'b1; end
                3'b110: if (lvl < n) begin r.rot = lvl; cmd_rot = 1'b1; end
                3'b100: r.raeoi = 1'b1;
                3'b000: r.raeoi = 1'b0;
                default: ;
            endcase
        end
        r.isr = s.isr & ~clr;
        if (st.latch && !st.aeoi) r.isr = r.isr | intr;
        if (st.latch && st.aeoi && s.raeoi && intr != 0 && !cmd_rot) r.rot = lowest_idx(intr);
        return r;
    endfunction

    function automatic exp_t exp_of(mstate_t s, int n, stim_t st);
        exp_t e;
        e.isr = s.isr;
        e.hi  = m_highest(s, n, st.smm, st.mask);
        e.rot = s.rot;
        e.any = ((s.isr & ~(st.smm ? st.mask : 32'd0)) != 0);
        return e;
    endfunction

    function automatic mstate_t m_reset(int n);
        mstate_t r;
        r.isr = 32'd0; r.rot = n - 1; r.raeoi = 1'b0;
        return r;
    endfunction

    function automatic stim_t base();
        stim_t s;
        s.latch = 1'b0; s.intr = 32'd0; s.aeoi = cur_aeoi; s.smm = cur_smm;
        s.mask = cur_mask; s.cv = 1'b0; s.code = 3'b010; s.level = 0;
        return s;
    endfunction

    function automatic stim_t s_lat(int irq);
        stim_t s;
        s = base(); s.latch = 1'b1; s.intr = 32'd1 << irq;
        return s;
    endfunction

    function automatic stim_t s_cmd(logic [2:0] code, int lvl);
        stim_t s;
        s = base(); s.cv = 1'b1; s.code = code; s.level = lvl;
        return s;
    endfunction

    task automatic drive(stim_t st);
        bus8.latch_in_service        = st.latch;
        bus8.interrupt               = 8'(st.intr);
        bus8.auto_eoi_mode           = st.aeoi;
        bus8.special_mask_mode       = st.smm;
        bus8.interrupt_special_mask  = 8'(st.mask);
        bus8.cmd_valid               = st.cv;
        bus8.cmd_code                = st.code;
        bus8.cmd_level               = 3'(st.level);
        bus12.latch_in_service       = st.latch;
        bus12.interrupt              = 12'(st.intr);
        bus12.auto_eoi_mode          = st.aeoi;
        bus12.special_mask_mode      = st.smm;
        bus12.interrupt_special_mask = 12'(st.mask);
        bus12.cmd_valid              = st.cv;
        bus12.cmd_code               = st.code;
        bus12.cmd_level              = 4'(st.level);
    endtask

    // Inputs change just after the falling edge; expectations queue just after the rising edge.
    task automatic step(stim_t st);
        @(negedge clk);
        #1;
        drive(st);
        @(posedge clk);
        m8  = m_step(m8, 8, st);
        m12 = m_step(m12, 12, st);
        #1;
        q8.push_back(exp_of(m8, 8, st));
        q12.push_back(exp_of(m12, 12, st));
        $display("step t=%0t latch=%0b intr=0x%0h aeoi=%0b smm=%0b cmd=%0b/%03b lvl=%0d -> isr8=0x%0h rot8=%0d isr12=0x%0h rot12=%0d",
                 $time, st.latch, st.intr, st.aeoi, st.smm, st.cv, st.code, st.level,
                 m8.isr, m8.rot, m12.isr, m12.rot);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_isr8",  32'(bus8.in_service_register), 32'd0);
        check("rst_hi8",   32'(bus8.highest_level_in_service), 32'd0);
        check("rst_rot8",  32'(bus8.priority_rotate), 32'd7);
        check("rst_any8",  32'(bus8.in_service_any), 32'd0);
        check("rst_isr12", 32'(bus12.in_service_register), 32'd0);
        check("rst_rot12", 32'(bus12.priority_rotate), 32'd11);
        m8  = m_reset(8);
        m12 = m_reset(12);
        $display("async reset applied at t=%0t", $time);
        #4;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst_n && bus12.latch_in_service) begin
            assert (allow_illegal || $countones(bus12.interrupt) <= 1)
                else $error("illegal multi-hot interrupt vector 0x%0h", bus12.interrupt);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("isr8", 32'(bus8.in_service_register), e.isr);
                check("hi8",  32'(bus8.highest_level_in_service), e.hi);
                check("rot8", 32'(bus8.priority_rotate), 32'(e.rot));
                check("any8", 32'(bus8.in_service_any), 32'(e.any));
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                check("isr12", 32'(bus12.in_service_register), e.isr);
                check("hi12",  32'(bus12.highest_level_in_service), e.hi);
                check("rot12", 32'(bus12.priority_rotate), 32'(e.rot));
                check("any12", 32'(bus12.in_service_any), 32'(e.any));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        m8  = m_reset(8);
        m12 = m_reset(12);
        drive(base());
        #17;
        rst_n = 1'b1;
        step(base());

        // Latch, non-specific EOI, rotate
        step(s_lat(3)); step(s_lat(1));
        step(s_cmd(3'b001, 0)); step(s_cmd(3'b001, 0)); step(s_cmd(3'b001, 0));
        step(s_lat(3)); step(s_lat(1));
        step(s_cmd(3'b101, 0)); step(s_lat(0));

        // Set priority and special mask
        step(s_cmd(3'b110, 4)); step(s_cmd(3'b011, 3)); step(s_lat(5));
        cur_smm = 1'b1; cur_mask = 32'h20;
        step(base());
        cur_smm = 1'b0; cur_mask = 32'd0;
        step(s_cmd(3'b011, 0)); step(s_cmd(3'b011, 5)); step(s_cmd(3'b110, 7));

        // Automatic EOI with and without rotation
        cur_aeoi = 1'b1;
        step(s_cmd(3'b100, 0)); step(s_lat(6)); step(s_cmd(3'b000, 0)); step(s_lat(2));
        step(s_cmd(3'b100, 0));
        s = s_lat(2); s.cv = 1'b1; s.code = 3'b110; s.level = 3;
        step(s);
        step(s_cmd(3'b000, 0));
        cur_aeoi = 1'b0;

        // Same-edge set/clear, out-of-range level, empty latch
        step(s_lat(5));
        s = s_lat(5); s.cv = 1'b1; s.code = 3'b011; s.level = 5;
        step(s);
        step(s_cmd(3'b011, 13));
        s = base(); s.latch = 1'b1;
        step(s);
        step(s_cmd(3'b111, 9)); step(s_cmd(3'b101, 0));

        // Deliberately multi-hot acknowledges
        allow_illegal = 1'b1;
        s = base(); s.latch = 1'b1; s.intr = 32'h0C;
        step(s);
        cur_aeoi = 1'b1;
        step(s_cmd(3'b100, 0));
        s = base(); s.latch = 1'b1; s.intr = 32'h30;
        step(s);
        step(s_cmd(3'b000, 0));
        cur_aeoi = 1'b0;
        allow_illegal = 1'b0;

        mid_reset();

        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            if ($urandom_range(0, 9) == 0) cur_aeoi = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                cur_smm  = ($urandom_range(0, 2) == 0);
                cur_mask = 32'($urandom_range(0, 4095));
            end
            s = base();
            if ($urandom_range(0, 9) < 4) begin
                s.latch = 1'b1;
                s.intr  = ($urandom_range(0, 9) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 11));
            end
            if ($urandom_range(0, 1) == 1) begin
                s.cv    = 1'b1;
                s.code  = 3'($urandom_range(0, 7));
                s.level = $urandom_range(0, 15);
            end
            step(s);
        end

        for (int w = 0; w < 10 && (q8.size() > 0 || q12.size() > 0); w++) @(negedge clk);
        #1;
        if (q8.size() > 0 || q12.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q8.size(), q12.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
